// File: rtl/snn_mem_pkg.sv
// ---------------------------------------------------------------------------
// snn_mem_pkg
// Shared types and helpers for the neuron state memory.
//   wr_op_t     : write operation select (overwrite or saturating add)
//   mem_state_t : clear sequencer states
//   sat_add()   : unsigned saturating add, clamped to 2^data_w - 1
// ---------------------------------------------------------------------------
package snn_mem_pkg;

    typedef enum logic {
        WR_OVERWRITE = 1'b0,
        WR_SAT_ADD   = 1'b1
    } wr_op_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } mem_state_t;

    // Widest word sat_add supports; callers zero-extend into this width.
    localparam int unsigned SAT_MAX_W = 32;

    // The sum is taken one bit wider than the operands so the carry is never
    // lost, then clamped to the all-ones value of a data_w-bit word.
    function automatic logic [SAT_MAX_W-1:0] sat_add(
        input logic [SAT_MAX_W-1:0] a,
        input logic [SAT_MAX_W-1:0] b,
        input int unsigned          data_w
    );
        logic [SAT_MAX_W:0] sum;
        logic [SAT_MAX_W:0] limit;
        sum   = {1'b0, a} + {1'b0, b};
        limit = ((SAT_MAX_W + 1)'(1) << data_w) - (SAT_MAX_W + 1)'(1);
        if (sum > limit) begin
            sat_add = limit[SAT_MAX_W-1:0];
        end else begin
            sat_add = sum[SAT_MAX_W-1:0];
        end
    endfunction

endpackage

// File: rtl/neuron_mem_init_seq.sv
// ---------------------------------------------------------------------------
// neuron_mem_init_seq
// Clear sequencer for the neuron state memory. After reset, or on clear_req
// while idle, it sweeps every entry once (one entry per cycle) and then
// returns to idle.
// Ports:
//   clock      in   rising-edge clock
//   reset_n    in   asynchronous active-low reset (starts a sweep on release)
//   clear_req  in   start a sweep; ignored while a sweep runs
//   busy       out  high while the sweep runs
//   clr_we     out  sweep write strobe for the memory array
//   clr_addr   out  entry being initialised this cycle
// ---------------------------------------------------------------------------
module neuron_mem_init_seq
    import snn_mem_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = $clog2(ENTRIES)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_we,
    output logic [ADDR_W-1:0] clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(ENTRIES - 1);

    mem_state_t        state;
    logic [ADDR_W-1:0] cnt;

    // Sweep FSM. Reset lands in CLEAR so the array is initialised straight
    // after power-up; busy is registered alongside the state so it drops in
    // the same cycle the FSM returns to idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            busy  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clear_req) begin
                        state <= ST_CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    if (cnt == LAST_ADDR) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + ADDR_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = (state == ST_CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/neuron_state_mem.sv
// ---------------------------------------------------------------------------
// neuron_state_mem
// ENTRIES x DATA_W register-array RAM holding per-neuron state. Supports
// overwrite and saturating-add writes, a registered read with valid flag,
// write-first bypass on same-address read/write, and a clear sweep that
// initialises every entry to INIT_VALUE after reset or on request.
// Optional feature macro: SNN_MEM_PARITY_EN (per-entry even parity and the
// parity_err output).
// Ports:
//   clock       in   rising-edge clock
//   reset_n     in   asynchronous active-low reset
//   clear_req   in   start a clear sweep (pulse)
//   busy        out  high while a clear sweep runs
//   w_en        in   write strobe
//   w_op        in   WR_OVERWRITE or WR_SAT_ADD
//   waddr       in   write address
//   data_in     in   write data / addend
//   rd_en       in   read request
//   raddr       in   read address
//   data_out    out  registered read data
//   rd_valid    out  data_out valid this cycle
//   parity_err  out  stored parity mismatch on the read (parity build only)
// ---------------------------------------------------------------------------
module neuron_state_mem
    import snn_mem_pkg::*;
#(
    parameter int                ENTRIES    = 16,
    parameter int                DATA_W     = 8,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0,
    localparam int               ADDR_W     = $clog2(ENTRIES)
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              clear_req,
    output logic              busy,
    input  logic              w_en,
    input  wr_op_t            w_op,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid
`ifdef SNN_MEM_PARITY_EN
    ,
    output logic              parity_err
`endif
);

`ifdef SNN_MEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0]  mem [ENTRIES];

    logic              clr_we;
    logic [ADDR_W-1:0] clr_addr;

    logic              waddr_ok;
    logic              raddr_ok;
    logic              user_we;
    logic              bypass;
    logic [DATA_W-1:0] old_word;
    logic [DATA_W-1:0] wr_data;
    logic [MEM_W-1:0]  rd_word;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MEM_W-1:0]  mem_wword;

    neuron_mem_init_seq #(
        .ENTRIES (ENTRIES),
        .ADDR_W  (ADDR_W)
    ) u_init_seq (
        .clock     (clock),
        .reset_n   (reset_n),
        .clear_req (clear_req),
        .busy      (busy),
        .clr_we    (clr_we),
        .clr_addr  (clr_addr)
    );

    // Address decode and user write data. The address field can encode more
    // values than there are entries when ENTRIES is not a power of two, so
    // every array access is guarded by a range check.
    always_comb begin
        waddr_ok = (32'(waddr) < ENTRIES);
        raddr_ok = (32'(raddr) < ENTRIES);
        user_we  = !busy && w_en && waddr_ok;
        bypass   = user_we && (waddr == raddr);

        old_word = '0;
        if (waddr_ok) begin
            old_word = mem[waddr][DATA_W-1:0];
        end

        rd_word = '0;
        if (raddr_ok) begin
            rd_word = mem[raddr];
        end

        if (w_op == WR_SAT_ADD) begin
            wr_data = DATA_W'(sat_add(SAT_MAX_W'(old_word), SAT_MAX_W'(data_in), DATA_W));
        end else begin
            wr_data = data_in;
        end
    end

    // Write port mux: the sweep owns the array while busy, so user writes
    // are only accepted when the sequencer is idle.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (clr_we) begin
            mem_we    = 1'b1;
            mem_waddr = clr_addr;
            mem_wdata = INIT_VALUE;
        end else if (user_we) begin
            mem_we    = 1'b1;
            mem_waddr = waddr;
            mem_wdata = wr_data;
        end
`ifdef SNN_MEM_PARITY_EN
        mem_wword = {^mem_wdata, mem_wdata};
`else
        mem_wword = mem_wdata;
`endif
    end

    // Storage array. Deliberately not reset: the clear sweep initialises it.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wword;
        end
    end

    // Registered read. A same-cycle write to the read address is forwarded
    // so the reader sees the post-write value, including an add result.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            data_out   <= '0;
            rd_valid   <= 1'b0;
`ifdef SNN_MEM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            rd_valid   <= 1'b0;
`ifdef SNN_MEM_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (!busy && rd_en) begin
                rd_valid <= 1'b1;
                if (!raddr_ok) begin
                    data_out <= '0;
                end else if (bypass) begin
                    data_out <= wr_data;
                end else begin
                    data_out <= rd_word[DATA_W-1:0];
`ifdef SNN_MEM_PARITY_EN
                    parity_err <= ^rd_word;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_neuron_state_mem.sv
// ---------------------------------------------------------------------------
// tb_neuron_state_mem
// Directed self-checking bench for neuron_state_mem. A 16-entry instance is
// the main device; a 12-entry instance shares its inputs to exercise
// addresses beyond the last entry. Parity checks are compiled in only when
// SNN_MEM_PARITY_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_neuron_state_mem;
    import snn_mem_pkg::*;

    logic       clock     = 1'b0;
    logic       reset_n   = 1'b0;
    logic       clear_req = 1'b0;
    logic       w_en      = 1'b0;
    wr_op_t     w_op      = WR_OVERWRITE;
    logic [3:0] waddr     = '0;
    logic [7:0] data_in   = '0;
    logic       rd_en     = 1'b0;
    logic [3:0] raddr     = '0;

    logic       busy,   busy12;
    logic [7:0] data_out, data_out12;
    logic       rd_valid, rd_valid12;
`ifdef SNN_MEM_PARITY_EN
    logic       parity_err, parity_err12;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    neuron_state_mem #(
        .ENTRIES    (16),
        .DATA_W     (8),
        .INIT_VALUE (8'h00)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_req  (clear_req),
        .busy       (busy),
        .w_en       (w_en),
        .w_op       (w_op),
        .waddr      (waddr),
        .data_in    (data_in),
        .rd_en      (rd_en),
        .raddr      (raddr),
        .data_out   (data_out),
        .rd_valid   (rd_valid)
`ifdef SNN_MEM_PARITY_EN
        ,
        .parity_err (parity_err)
`endif
    );

    neuron_state_mem #(
        .ENTRIES    (12),
        .DATA_W     (8),
        .INIT_VALUE (8'h00)
    ) dut12 (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_req  (clear_req),
        .busy       (busy12),
        .w_en       (w_en),
        .w_op       (w_op),
        .waddr      (waddr),
        .data_in    (data_in),
        .rd_en      (rd_en),
        .raddr      (raddr),
        .data_out   (data_out12),
        .rd_valid   (rd_valid12)
`ifdef SNN_MEM_PARITY_EN
        ,
        .parity_err (parity_err12)
`endif
    );

    // One clock cycle of stimulus: inputs change on the falling edge, the
    // outputs are sampled 1 ns after the rising edge, then strobes drop.
    task automatic drive(input logic we, input wr_op_t op, input logic [3:0] wa,
                         input logic [7:0] d, input logic re, input logic [3:0] ra,
                         input logic clr);
        @(negedge clock);
        w_en      = we;
        w_op      = op;
        waddr     = wa;
        data_in   = d;
        rd_en     = re;
        raddr     = ra;
        clear_req = clr;
        @(posedge clock);
        #1;
        w_en      = 1'b0;
        rd_en     = 1'b0;
        clear_req = 1'b0;
    endtask

    task automatic test_reset;
        int n;
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 1", busy); end
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rd_valid: got %b expected 0", rd_valid); end
        n_cmp++; if (data_out !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_data_out: got %0d expected 0", data_out); end
        @(negedge clock);
        reset_n = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            @(posedge clock);
            #1;
            n++;
        end
        n_cmp++; if (n !== 16) begin n_fail++; $display("[TB] FAIL reset_sweep_len: got %0d cycles expected 16", n); end
        n_cmp++; if (busy12 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy12: got %b expected 0", busy12); end
    endtask

    task automatic test_read_all_init;
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0, 1'b1, 4'(i), 1'b0);
            n_cmp++;
            if (rd_valid !== 1'b1 || data_out !== 8'd0) begin
                n_fail++;
                $display("[TB] FAIL init_read[%0d]: got valid=%b data=%0d expected valid=1 data=0", i, rd_valid, data_out);
            end
        end
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0);
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL init_idle_valid: got %b expected 0", rd_valid); end
    endtask

    task automatic test_overwrite;
        drive(1'b1, WR_OVERWRITE, 4'd3, 8'd5, 1'b0, 4'd0, 1'b0);
        n_cmp++; if (rd_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL ow_no_read_valid: got %b expected 0", rd_valid); end
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0, 1'b1, 4'd4, 1'b0);
        n_cmp++; if (rd_valid !== 1'b1 || data_out !== 8'd0) begin n_fail++; $display("[TB] FAIL ow_read4: got valid=%b data=%0d expected valid=1 data=0", rd_valid, data_out); end
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0, 1'b1, 4'd3, 1'b0);
        n_cmp++; if (rd_valid !== 1'b1 || data_out !== 8'd5) begin n_fail++; $display("[TB] FAIL ow_read3: got valid=%b data=%0d expected valid=1 data=5", rd_valid, data_out); end
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0);
        n_cmp++; if (rd_valid !== 1'b0 || data_out !== 8'd5) begin n_fail++; $display("[TB] FAIL ow_hold: got valid=%b data=%0d expected valid=0 data=5", rd_valid, data_out); end
    endtask

    task automatic test_saturate;
        drive(1'b1, WR_OVERWRITE, 4'd7, 8'd200, 1'b0, 4'd0, 1'b0);
        drive(1'b1, WR_SAT_ADD,   4'd7, 8'd100, 1'b0, 4'd0, 1'b0);
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0,   1'b1, 4'd7, 1'b0);
        n_cmp++; if (data_out !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_200p100: got %0d expected 255", data_out); end
        drive(1'b1, WR_SAT_ADD,   4'd7, 8'd0,   1'b0, 4'd0, 1'b0);
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0,   1'b1, 4'd7, 1'b0);
        n_cmp++; if (data_out !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_add0: got %0d expected 255", data_out); end
        drive(1'b1, WR_OVERWRITE, 4'd8, 8'd200, 1'b0, 4'd0, 1'b0);
        drive(1'b1, WR_SAT_ADD,   4'd8, 8'd55,  1'b0, 4'd0, 1'b0);
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0,   1'b1, 4'd8, 1'b0);
        n_cmp++; if (data_out !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_exact_max: got %0d expected 255", data_out); end
        drive(1'b1, WR_OVERWRITE, 4'd9, 8'd100, 1'b0, 4'd0, 1'b0);
        drive(1'b1, WR_SAT_ADD,   4'd9, 8'd27,  1'b0, 4'd0, 1'b0);
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0,   1'b1, 4'd9, 1'b0);
        n_cmp++; if (data_out !== 8'd127) begin n_fail++; $display("[TB] FAIL add_100p27: got %0d expected 127", data_out); end
        drive(1'b1, WR_SAT_ADD,   4'd9, 8'd1,   1'b0, 4'd0, 1'b0);
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0,   1'b1, 4'd9, 1'b0);
        n_cmp++; if (data_out !== 8'd128) begin n_fail++; $display("[TB] FAIL add_127p1: got %0d expected 128", data_out); end
    endtask

    task automatic test_back_to_back;
        drive(1'b1, WR_OVERWRITE, 4'd2, 8'd5,  1'b0, 4'd0, 1'b0);
        drive(1'b1, WR_SAT_ADD,   4'd2, 8'd10, 1'b1, 4'd2, 1'b0);
        n_cmp++; if (rd_valid !== 1'b1 || data_out !== 8'd15) begin n_fail++; $display("[TB] FAIL bypass_add: got valid=%b data=%0d expected valid=1 data=15", rd_valid, data_out); end
        drive(1'b1, WR_OVERWRITE, 4'd2, 8'd77, 1'b1, 4'd2, 1'b0);
        n_cmp++; if (data_out !== 8'd77) begin n_fail++; $display("[TB] FAIL bypass_ow: got %0d expected 77", data_out); end
        drive(1'b1, WR_OVERWRITE, 4'd6, 8'd33, 1'b1, 4'd2, 1'b0);
        n_cmp++; if (data_out !== 8'd77) begin n_fail++; $display("[TB] FAIL diff_addr_read: got %0d expected 77", data_out); end
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0,  1'b1, 4'd6, 1'b0);
        n_cmp++; if (data_out !== 8'd33) begin n_fail++; $display("[TB] FAIL b2b_read6: got %0d expected 33", data_out); end
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0,  1'b1, 4'd3, 1'b0);
        n_cmp++; if (rd_valid !== 1'b1 || data_out !== 8'd5) begin n_fail++; $display("[TB] FAIL b2b_read3: got valid=%b data=%0d expected valid=1 data=5", rd_valid, data_out); end
    endtask

    task automatic test_clear_req;
        int n;
        int valid_seen;
        drive(1'b1, WR_OVERWRITE, 4'd1, 8'd9, 1'b0, 4'd0, 1'b0);
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0, 1'b1, 4'd1, 1'b0);
        n_cmp++; if (data_out !== 8'd9) begin n_fail++; $display("[TB] FAIL clr_pre_read1: got %0d expected 9", data_out); end
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL clr_busy_rise: got %b expected 1", busy); end
        n = 0;
        valid_seen = 0;
        while (busy === 1'b1 && n < 40) begin
            drive(n >= 8, WR_OVERWRITE, 4'd1, 8'd9, n >= 8, 4'd1, n == 5);
            if (rd_valid !== 1'b0) valid_seen++;
            n++;
        end
        n_cmp++; if (n !== 16) begin n_fail++; $display("[TB] FAIL clr_sweep_len: got %0d cycles expected 16", n); end
        n_cmp++; if (valid_seen !== 0) begin n_fail++; $display("[TB] FAIL clr_busy_valid: got %0d valid cycles expected 0", valid_seen); end
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0, 1'b1, 4'd1, 1'b0);
        n_cmp++; if (rd_valid !== 1'b1 || data_out !== 8'd0) begin n_fail++; $display("[TB] FAIL clr_post_read1: got valid=%b data=%0d expected valid=1 data=0", rd_valid, data_out); end
    endtask

    task automatic test_reset_mid_sweep;
        int n;
        int valid_seen;
        drive(1'b1, WR_OVERWRITE, 4'd1, 8'd9, 1'b0, 4'd0, 1'b0);
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0, 1'b1, 4'd1, 1'b0);
        n_cmp++; if (data_out !== 8'd9) begin n_fail++; $display("[TB] FAIL rst_pre_read1: got %0d expected 9", data_out); end
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0, 1'b0, 4'd0, 1'b1);
        repeat (5) drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        n_cmp++; if (data_out !== 8'd0) begin n_fail++; $display("[TB] FAIL rst_async_data: got %0d expected 0", data_out); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("[TB] FAIL rst_async_busy: got %b expected 1", busy); end
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        n = 0;
        valid_seen = 0;
        // Counting starts at the release edge; stimulus lands on later falling edges.
        @(posedge clock);
        #1;
        n++;
        while (busy === 1'b1 && n < 40) begin
            drive(n >= 10, WR_OVERWRITE, 4'd5, 8'd99, n >= 10, 4'd5, 1'b0);
            if (rd_valid !== 1'b0) valid_seen++;
            n++;
        end
        n_cmp++; if (n !== 16) begin n_fail++; $display("[TB] FAIL rst_sweep_len: got %0d cycles expected 16", n); end
        n_cmp++; if (valid_seen !== 0) begin n_fail++; $display("[TB] FAIL rst_busy_valid: got %0d valid cycles expected 0", valid_seen); end
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0, 1'b1, 4'd1, 1'b0);
        n_cmp++; if (data_out !== 8'd0) begin n_fail++; $display("[TB] FAIL rst_post_read1: got %0d expected 0", data_out); end
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0, 1'b1, 4'd5, 1'b0);
        n_cmp++; if (data_out !== 8'd0) begin n_fail++; $display("[TB] FAIL rst_busy_write5: got %0d expected 0", data_out); end
    endtask

    task automatic test_out_of_range;
        drive(1'b1, WR_OVERWRITE, 4'd11, 8'd42, 1'b0, 4'd0, 1'b0);
        drive(1'b1, WR_OVERWRITE, 4'd13, 8'd77, 1'b0, 4'd0, 1'b0);
        drive(1'b1, WR_SAT_ADD,   4'd13, 8'd1,  1'b0, 4'd0, 1'b0);
        drive(1'b0, WR_OVERWRITE, 4'd0,  8'd0,  1'b1, 4'd13, 1'b0);
        n_cmp++; if (rd_valid12 !== 1'b1 || data_out12 !== 8'd0) begin n_fail++; $display("[TB] FAIL oor_read13: got valid=%b data=%0d expected valid=1 data=0", rd_valid12, data_out12); end
        n_cmp++; if (data_out !== 8'd78) begin n_fail++; $display("[TB] FAIL inrange16_read13: got %0d expected 78", data_out); end
`ifdef SNN_MEM_PARITY_EN
        n_cmp++; if (parity_err12 !== 1'b0) begin n_fail++; $display("[TB] FAIL oor_parity: got %b expected 0", parity_err12); end
`endif
        drive(1'b0, WR_OVERWRITE, 4'd0,  8'd0,  1'b1, 4'd11, 1'b0);
        n_cmp++; if (rd_valid12 !== 1'b1 || data_out12 !== 8'd42) begin n_fail++; $display("[TB] FAIL last_entry12: got valid=%b data=%0d expected valid=1 data=42", rd_valid12, data_out12); end
        drive(1'b1, WR_OVERWRITE, 4'd12, 8'd5,  1'b0, 4'd0, 1'b0);
        drive(1'b0, WR_OVERWRITE, 4'd0,  8'd0,  1'b1, 4'd12, 1'b0);
        n_cmp++; if (rd_valid12 !== 1'b1 || data_out12 !== 8'd0) begin n_fail++; $display("[TB] FAIL oor_read12: got valid=%b data=%0d expected valid=1 data=0", rd_valid12, data_out12); end
        n_cmp++; if (data_out !== 8'd5) begin n_fail++; $display("[TB] FAIL inrange16_read12: got %0d expected 5", data_out); end
    endtask

`ifdef SNN_MEM_PARITY_EN
    task automatic test_parity;
        drive(1'b1, WR_OVERWRITE, 4'd3, 8'd5, 1'b0, 4'd0, 1'b0);
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0, 1'b1, 4'd3, 1'b0);
        n_cmp++; if (parity_err !== 1'b0) begin n_fail++; $display("[TB] FAIL parity_clean: got %b expected 0", parity_err); end
        dut.mem[3] = dut.mem[3] ^ 9'h004;
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0, 1'b1, 4'd3, 1'b0);
        n_cmp++; if (parity_err !== 1'b1 || rd_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL parity_flip: got err=%b valid=%b expected err=1 valid=1", parity_err, rd_valid); end
        drive(1'b0, WR_OVERWRITE, 4'd0, 8'd0, 1'b0, 4'd0, 1'b0);
        n_cmp++; if (parity_err !== 1'b0) begin n_fail++; $display("[TB] FAIL parity_hold: got %b expected 0", parity_err); end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not reach the summary");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        test_reset();
        test_read_all_init();
        test_overwrite();
        test_saturate();
        test_back_to_back();
        test_clear_req();
        test_reset_mid_sweep();
        test_out_of_range();
`ifdef SNN_MEM_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
